// File: rtl/tt_sweep_checker.sv
// ---------------------------------------------------------------------------
// tt_sweep_checker
//   Hardware self-test for a small combinational block. Drives every input
//   vector 0..2^N_IN-1 onto the block, lets it settle for SETTLE cycles,
//   samples the block's outputs for one cycle and compares them against a
//   golden truth table. Counts mismatching vectors, latches the lowest
//   failing vector and reports pass/fail when the sweep completes.
//
// Parameters
//   N_IN    number of block inputs  (stim = {A,B,C,D}, MSB = A)
//   N_OUT   number of block outputs (resp = {f,g,h}, MSB = f)
//   SETTLE  cycles stim is held before sampling (>= 1)
//   GOLDEN  truth table; GOLDEN[v*N_OUT +: N_OUT] = expected resp for v
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   asynchronous, active-low reset
//   start            in   request a sweep (honoured only in IDLE or DONE)
//   stim             out  registered vector driven to the block inputs
//   resp             in   block outputs (combinational from stim)
//   busy             out  sweep in progress
//   done             out  sweep finished, held until next start or reset
//   pass             out  done with zero mismatches
//   err_count        out  number of mismatching vectors (0..2^N_IN)
//   first_fail_vec   out  lowest mismatching vector index
//   first_fail_valid out  first_fail_vec holds a valid index
//   mismatch         out  one-cycle pulse after each failing compare edge
// ---------------------------------------------------------------------------
module tt_sweep_checker #(
    parameter int unsigned                     N_IN   = 4,
    parameter int unsigned                     N_OUT  = 3,
    parameter int unsigned                     SETTLE = 2,
    parameter logic [(2**N_IN)*N_OUT-1:0]      GOLDEN = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [N_IN-1:0]   stim,
    input  logic [N_OUT-1:0]  resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic              first_fail_valid,
    output logic              mismatch
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [N_IN-1:0]     stim_n;
    logic                busy_n, done_n, pass_n;
    logic [N_IN:0]       err_n;
    logic [N_IN-1:0]     ffv_n;
    logic                ffvalid_n;
    logic                mismatch_n;
    logic [N_OUT-1:0]    expected;
    logic                miss;

    // stim doubles as the sweep's vector index
    always_comb begin
        expected = GOLDEN[int'(stim) * int'(N_OUT) +: N_OUT];
        miss     = (resp != expected);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            cnt              <= '0;
            stim             <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            mismatch         <= 1'b0;
        end else begin
            state            <= state_n;
            cnt              <= cnt_n;
            stim             <= stim_n;
            busy             <= busy_n;
            done             <= done_n;
            pass             <= pass_n;
            err_count        <= err_n;
            first_fail_vec   <= ffv_n;
            first_fail_valid <= ffvalid_n;
            mismatch         <= mismatch_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        stim_n     = stim;
        busy_n     = busy;
        done_n     = done;
        pass_n     = pass;
        err_n      = err_count;
        ffv_n      = first_fail_vec;
        ffvalid_n  = first_fail_valid;
        mismatch_n = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    stim_n    = '0;
                    err_n     = '0;
                    ffv_n     = '0;
                    ffvalid_n = 1'b0;
                    done_n    = 1'b0;
                    pass_n    = 1'b0;
                    busy_n    = 1'b1;
                    cnt_n     = CNT_LOAD;
                    state_n   = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (cnt == '0) begin
                    state_n = S_SAMPLE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end

            S_SAMPLE: begin
                if (miss) begin
                    err_n      = err_count + (N_IN+1)'(1);
                    mismatch_n = 1'b1;
                    if (!first_fail_valid) begin
                        ffv_n     = stim;
                        ffvalid_n = 1'b1;
                    end
                end
                if (stim == '1) begin
                    // pass reflects the count including this last compare
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (err_n == '0);
                    state_n = S_DONE;
                end else begin
                    stim_n  = stim + N_IN'(1);
                    cnt_n   = CNT_LOAD;
                    state_n = S_SETTLE;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

endmodule
